// File: rtl/hyperbus_burst_ctrl_if.sv
// Command, write-data, read-data, status and PHY signals of the HyperBus burst controller.
// slave is the controller's view; master is the user/PHY-model side.
interface hyperbus_burst_ctrl_if #(
    parameter int WIDTH       = 8,
    parameter int ADDR_LENGTH = 32,
    parameter int LEN_WIDTH   = 8
);
    logic                   cmd_valid_i;
    logic                   cmd_ready_o;
    logic                   cmd_we_i;
    logic                   cmd_reg_i;
    logic [ADDR_LENGTH-1:0] cmd_adr_i;
    logic [LEN_WIDTH-1:0]   cmd_len_i;

    logic [2*WIDTH-1:0]     wdat_i;
    logic [1:0]             wmask_i;
    logic                   wvalid_i;
    logic                   wready_o;

    logic [2*WIDTH-1:0]     rdat_o;
    logic                   rvalid_o;
    logic                   busy_o;
    logic                   error_o;
    logic                   err_clr_i;

    logic [2*WIDTH-1:0]     phy_dq_o;
    logic                   phy_dq_oe;
    logic [2*WIDTH-1:0]     phy_dq_i;
    logic [1:0]             phy_rwds_o;
    logic                   phy_rwds_oe;
    logic [1:0]             phy_rwds_i;
    logic                   phy_clk_en;
    logic                   phy_csn;
    logic                   phy_rstn;

    modport slave (
        input  cmd_valid_i, cmd_we_i, cmd_reg_i, cmd_adr_i, cmd_len_i,
        input  wdat_i, wmask_i, wvalid_i, err_clr_i, phy_dq_i, phy_rwds_i,
        output cmd_ready_o, wready_o, rdat_o, rvalid_o, busy_o, error_o,
        output phy_dq_o, phy_dq_oe, phy_rwds_o, phy_rwds_oe, phy_clk_en, phy_csn, phy_rstn
    );

    modport master (
        output cmd_valid_i, cmd_we_i, cmd_reg_i, cmd_adr_i, cmd_len_i,
        output wdat_i, wmask_i, wvalid_i, err_clr_i, phy_dq_i, phy_rwds_i,
        input  cmd_ready_o, wready_o, rdat_o, rvalid_o, busy_o, error_o,
        input  phy_dq_o, phy_dq_oe, phy_rwds_o, phy_rwds_oe, phy_clk_en, phy_csn, phy_rstn
    );
endinterface

// File: rtl/hyperbus_burst_ctrl.sv
// HyperBus burst controller: one command at a time, CA phase, 1x/2x latency, write/read burst, CS# recovery.
// Write words stall on wvalid_i (clock gated); read words are strobed by rwds and delivered one cycle later.
module hyperbus_burst_ctrl #(
    parameter int WIDTH         = 8,
    parameter int ADDR_LENGTH   = 32,
    parameter int LEN_WIDTH     = 8,
    parameter int TACC_COUNT    = 5,
    parameter int FIXED_LATENCY = 0,
    parameter int RESET_COUNT   = 2,
    parameter int RECOVER_COUNT = 2,
    parameter int TIMEOUT_COUNT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    hyperbus_burst_ctrl_if.slave   bus
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_RESET, S_IDLE, S_COMMAND, S_LATENCY, S_WRITE, S_READ, S_RECOVER, S_ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [47:0]          ca_q, ca_d;
    logic                 we_q, we_d;
    logic                 reg_q, reg_d;
    logic                 lat2_q, lat2_d;
    logic                 rvalid_q, rvalid_d;
    logic [DW-1:0]        rdat_q, rdat_d;

    logic                 strobe;
    logic [28:0]          row;

    assign strobe = (bus.phy_rwds_i == 2'b10);
    assign row    = 29'(bus.cmd_adr_i >> 3);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        len_d    = len_q;
        ca_d     = ca_q;
        we_d     = we_q;
        reg_d    = reg_q;
        lat2_d   = lat2_q;
        rvalid_d = 1'b0;
        rdat_d   = rdat_q;
        case (state_q)
            S_RESET: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    state_d = S_COMMAND;
                    cnt_d   = '0;
                    we_d    = bus.cmd_we_i;
                    reg_d   = bus.cmd_reg_i;
                    ca_d    = {~bus.cmd_we_i, bus.cmd_reg_i, 1'b1, row, 13'b0, bus.cmd_adr_i[2:0]};
                    len_d   = bus.cmd_reg_i ? '0 : bus.cmd_len_i;
                end
            end
            S_COMMAND: begin
                if (cnt_q == '0) lat2_d = (|bus.phy_rwds_i) || (FIXED_LATENCY != 0);
                if (cnt_q == CW'(2)) begin
                    wcnt_d = '0;
                    // Register writes carry their data straight after the CA words.
                    if (reg_q && we_q) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_LATENCY;
                        cnt_d   = lat2_q ? CW'(2 * TACC_COUNT - 1) : CW'(TACC_COUNT - 1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LATENCY: begin
                if (cnt_q == '0) begin
                    state_d = we_q ? S_WRITE : S_READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WRITE: begin
                if (bus.wvalid_i) begin
                    if (wcnt_q == len_q) begin
                        state_d = S_RECOVER;
                        cnt_d   = CW'(RECOVER_COUNT - 1);
                    end else begin
                        wcnt_d = wcnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            S_READ: begin
                // cnt_q doubles as the strobe timeout counter while reading.
                if (strobe) begin
                    rvalid_d = 1'b1;
                    rdat_d   = bus.phy_dq_i;
                    cnt_d    = '0;
                    if (wcnt_q == len_q) begin
                        state_d = S_RECOVER;
                        cnt_d   = CW'(RECOVER_COUNT - 1);
                    end else begin
                        wcnt_d = wcnt_q + LEN_WIDTH'(1);
                    end
                end else if (cnt_q == CW'(TIMEOUT_COUNT - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RECOVER: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_ERROR: begin
                if (bus.err_clr_i) begin
                    state_d = S_RECOVER;
                    cnt_d   = CW'(RECOVER_COUNT - 1);
                end
            end
            default: begin
                state_d = S_RESET;
                cnt_d   = CW'(RESET_COUNT);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RESET;
            cnt_q    <= CW'(RESET_COUNT);
            wcnt_q   <= '0;
            len_q    <= '0;
            ca_q     <= '0;
            we_q     <= 1'b0;
            reg_q    <= 1'b0;
            lat2_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            len_q    <= len_d;
            ca_q     <= ca_d;
            we_q     <= we_d;
            reg_q    <= reg_d;
            lat2_q   <= lat2_d;
            rvalid_q <= rvalid_d;
            rdat_q   <= rdat_d;
        end
    end

    always_comb begin
        bus.cmd_ready_o = (state_q == S_IDLE);
        bus.busy_o      = (state_q != S_IDLE);
        bus.wready_o    = (state_q == S_WRITE);
        bus.error_o     = (state_q == S_ERROR);
        bus.rvalid_o    = rvalid_q;
        bus.rdat_o      = rdat_q;
        bus.phy_rstn    = (state_q != S_RESET);
        bus.phy_csn     = !((state_q == S_COMMAND) || (state_q == S_LATENCY) ||
                            (state_q == S_WRITE)   || (state_q == S_READ));
        bus.phy_clk_en  = 1'b0;
        bus.phy_dq_oe   = 1'b0;
        bus.phy_rwds_oe = 1'b0;
        bus.phy_dq_o    = '0;
        bus.phy_rwds_o  = 2'b00;
        case (state_q)
            S_COMMAND: begin
                bus.phy_clk_en = 1'b1;
                bus.phy_dq_oe  = 1'b1;
                case (cnt_q)
                    CW'(0):  bus.phy_dq_o = DW'(ca_q[47:32]);
                    CW'(1):  bus.phy_dq_o = DW'(ca_q[31:16]);
                    default: bus.phy_dq_o = DW'(ca_q[15:0]);
                endcase
            end
            S_LATENCY, S_READ: bus.phy_clk_en = 1'b1;
            S_WRITE: begin
                bus.phy_clk_en  = bus.wvalid_i;
                bus.phy_dq_oe   = 1'b1;
                bus.phy_rwds_oe = !reg_q;
                bus.phy_dq_o    = bus.wdat_i;
                bus.phy_rwds_o  = bus.wmask_i;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// Directed bench for hyperbus_burst_ctrl: reset, linear read, stalled write, register write, read timeout, mid-burst reset.
module tb_hyperbus_burst_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    hyperbus_burst_ctrl_if #(.WIDTH(8), .ADDR_LENGTH(32), .LEN_WIDTH(8)) bus();

    hyperbus_burst_ctrl #(
        .WIDTH(8), .ADDR_LENGTH(32), .LEN_WIDTH(8), .TACC_COUNT(5), .FIXED_LATENCY(0),
        .RESET_COUNT(2), .RECOVER_COUNT(2), .TIMEOUT_COUNT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.cmd_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        settle();
        chk(tag, 32'(bus.cmd_ready_o), 32'd1);
    endtask

    task automatic wait_wready(input string tag, input int exp_n);
        int n = 0;
        while (bus.wready_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    // Issue one command from IDLE; returns in the first COMMAND cycle.
    task automatic send_cmd(input logic we, input logic rg, input logic [31:0] adr,
                            input logic [7:0] len, input logic [1:0] rwds);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_reg_i   = rg;
        bus.cmd_adr_i   = adr;
        bus.cmd_len_i   = len;
        bus.phy_rwds_i  = rwds;
        settle();
        chk("cmd_ready_before_accept", 32'(bus.cmd_ready_o), 32'd1);
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst             = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_reg_i   = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_len_i   = '0;
        bus.wdat_i      = '0;
        bus.wmask_i     = 2'b00;
        bus.wvalid_i    = 1'b0;
        bus.err_clr_i   = 1'b0;
        bus.phy_dq_i    = '0;
        bus.phy_rwds_i  = 2'b00;

        // Reset and release
        tick(); tick(); tick();
        settle();
        chk("rst_rstn", 32'(bus.phy_rstn), 32'd0);
        chk("rst_csn", 32'(bus.phy_csn), 32'd1);
        chk("rst_busy", 32'(bus.busy_o), 32'd1);
        chk("rst_ready", 32'(bus.cmd_ready_o), 32'd0);
        rst = 1'b0;
        n = 0;
        while (bus.phy_rstn !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        settle();
        chk("rstn_low_cycles", 32'(n), 32'd3);
        chk("idle_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("idle_csn", 32'(bus.phy_csn), 32'd1);
        chk("idle_busy", 32'(bus.busy_o), 32'd0);

        // Linear read, adr 0x123, 4 words, 1x latency
        send_cmd(1'b0, 1'b0, 32'h0000_0123, 8'd3, 2'b00);
        settle();
        chk("rd_ca0", 32'(bus.phy_dq_o), 32'h0000_A000);
        chk("rd_ca_oe", 32'(bus.phy_dq_oe), 32'd1);
        chk("rd_ca_csn", 32'(bus.phy_csn), 32'd0);
        chk("rd_ca_clken", 32'(bus.phy_clk_en), 32'd1);
        tick(); settle();
        chk("rd_ca1", 32'(bus.phy_dq_o), 32'h0000_0024);
        tick(); settle();
        chk("rd_ca2", 32'(bus.phy_dq_o), 32'h0000_0003);
        tick();
        // Strobes during latency must be ignored
        bus.phy_rwds_i = 2'b10;
        bus.phy_dq_i   = 16'hDEAD;
        settle();
        chk("rd_lat_oe", 32'(bus.phy_dq_oe), 32'd0);
        chk("rd_lat_clken", 32'(bus.phy_clk_en), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("rd_lat_no_rvalid", 32'(bus.rvalid_o), 32'd0);
            tick();
        end
        bus.phy_dq_i = 16'h1111;
        tick(); settle();
        chk("rd_w0_vld", 32'(bus.rvalid_o), 32'd1);
        chk("rd_w0_dat", 32'(bus.rdat_o), 32'h1111);
        bus.phy_rwds_i = 2'b01;
        bus.phy_dq_i   = 16'hBEEF;
        tick(); settle();
        chk("rd_gap_vld", 32'(bus.rvalid_o), 32'd0);
        chk("rd_gap_hold", 32'(bus.rdat_o), 32'h1111);
        bus.phy_rwds_i = 2'b10;
        bus.phy_dq_i   = 16'h2222;
        tick();
        bus.phy_dq_i = 16'h3333;
        settle();
        chk("rd_w1_dat", 32'(bus.rdat_o), 32'h2222);
        tick();
        bus.phy_dq_i = 16'h4444;
        settle();
        chk("rd_w2_dat", 32'(bus.rdat_o), 32'h3333);
        tick();
        bus.phy_rwds_i = 2'b00;
        settle();
        chk("rd_w3_vld", 32'(bus.rvalid_o), 32'd1);
        chk("rd_w3_dat", 32'(bus.rdat_o), 32'h4444);
        chk("rd_rec_clken", 32'(bus.phy_clk_en), 32'd0);
        chk("rd_rec_csn", 32'(bus.phy_csn), 32'd1);
        tick(); settle();
        chk("rd_rec2_vld", 32'(bus.rvalid_o), 32'd0);
        chk("rd_rec2_busy", 32'(bus.busy_o), 32'd1);
        tick(); settle();
        chk("rd_back_idle", 32'(bus.cmd_ready_o), 32'd1);

        // Write adr 0x10, 2 words, 2x latency, 2-cycle stall
        send_cmd(1'b1, 1'b0, 32'h0000_0010, 8'd1, 2'b11);
        settle();
        chk("wr_ca0", 32'(bus.phy_dq_o), 32'h0000_2000);
        tick(); settle();
        chk("wr_ca1", 32'(bus.phy_dq_o), 32'h0000_0002);
        tick(); settle();
        chk("wr_ca2", 32'(bus.phy_dq_o), 32'h0000_0000);
        tick();
        bus.phy_rwds_i = 2'b00;
        wait_wready("wr_latency_2x", 10);
        bus.wvalid_i = 1'b1;
        bus.wdat_i   = 16'hA1B2;
        bus.wmask_i  = 2'b01;
        settle();
        chk("wr_w0_dq", 32'(bus.phy_dq_o), 32'hA1B2);
        chk("wr_w0_rwds", 32'(bus.phy_rwds_o), 32'h1);
        chk("wr_w0_rwds_oe", 32'(bus.phy_rwds_oe), 32'd1);
        chk("wr_w0_clken", 32'(bus.phy_clk_en), 32'd1);
        tick();
        bus.wvalid_i = 1'b0;
        bus.wdat_i   = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("wr_stall_clken", 32'(bus.phy_clk_en), 32'd0);
            chk("wr_stall_csn", 32'(bus.phy_csn), 32'd0);
            chk("wr_stall_wready", 32'(bus.wready_o), 32'd1);
            tick();
        end
        bus.wvalid_i = 1'b1;
        bus.wdat_i   = 16'hC3D4;
        bus.wmask_i  = 2'b10;
        settle();
        chk("wr_w1_dq", 32'(bus.phy_dq_o), 32'hC3D4);
        chk("wr_w1_rwds", 32'(bus.phy_rwds_o), 32'h2);
        tick();
        bus.wvalid_i = 1'b0;
        settle();
        chk("wr_done_wready", 32'(bus.wready_o), 32'd0);
        chk("wr_done_csn", 32'(bus.phy_csn), 32'd1);
        wait_idle("wr_back_idle");

        // Register write: zero latency, one word, rwds not driven
        send_cmd(1'b1, 1'b1, 32'h0000_0000, 8'd5, 2'b00);
        settle();
        chk("reg_ca_top3", 32'(bus.phy_dq_o[15:13]), 32'h3);
        tick(); tick(); tick(); settle();
        chk("reg_wready", 32'(bus.wready_o), 32'd1);
        chk("reg_rwds_oe", 32'(bus.phy_rwds_oe), 32'd0);
        chk("reg_dq_oe", 32'(bus.phy_dq_oe), 32'd1);
        bus.wvalid_i = 1'b1;
        bus.wdat_i   = 16'h8F1F;
        tick();
        bus.wvalid_i = 1'b0;
        settle();
        chk("reg_one_word", 32'(bus.wready_o), 32'd0);
        wait_idle("reg_back_idle");

        // Read with no strobes: timeout, error, clear
        send_cmd(1'b0, 1'b0, 32'h0000_0000, 8'd0, 2'b00);
        for (int i = 0; i < 8; i++) tick();
        n = 0;
        while (bus.error_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        settle();
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_error", 32'(bus.error_o), 32'd1);
        chk("to_csn", 32'(bus.phy_csn), 32'd1);
        chk("to_ready", 32'(bus.cmd_ready_o), 32'd0);
        tick(); settle();
        chk("to_error_held", 32'(bus.error_o), 32'd1);
        bus.err_clr_i = 1'b1;
        tick();
        bus.err_clr_i = 1'b0;
        settle();
        chk("to_clr_error", 32'(bus.error_o), 32'd0);
        chk("to_clr_busy", 32'(bus.busy_o), 32'd1);
        tick(); tick(); settle();
        chk("to_back_idle", 32'(bus.cmd_ready_o), 32'd1);

        // Reset during second write word
        send_cmd(1'b1, 1'b0, 32'h0000_0040, 8'd3, 2'b00);
        tick(); tick(); tick();
        wait_wready("wr_latency_1x", 5);
        bus.wvalid_i = 1'b1;
        bus.wdat_i   = 16'h1234;
        tick();
        rst         = 1'b1;
        bus.wdat_i  = 16'h5678;
        tick(); settle();
        chk("mr_rstn", 32'(bus.phy_rstn), 32'd0);
        chk("mr_csn", 32'(bus.phy_csn), 32'd1);
        chk("mr_clken", 32'(bus.phy_clk_en), 32'd0);
        chk("mr_dq_oe", 32'(bus.phy_dq_oe), 32'd0);
        chk("mr_rwds_oe", 32'(bus.phy_rwds_oe), 32'd0);
        chk("mr_ready", 32'(bus.cmd_ready_o), 32'd0);
        chk("mr_wready", 32'(bus.wready_o), 32'd0);
        chk("mr_rvalid", 32'(bus.rvalid_o), 32'd0);
        chk("mr_error", 32'(bus.error_o), 32'd0);
        chk("mr_busy", 32'(bus.busy_o), 32'd1);
        chk("mr_rdat", 32'(bus.rdat_o), 32'h0);
        tick(); settle();
        chk("mr_wready_held", 32'(bus.wready_o), 32'd0);
        rst          = 1'b0;
        bus.wvalid_i = 1'b0;
        wait_idle("mr_back_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hyperbus_burst_ctrl.md
HYPERBUS_BURST_CTRL -- requirements
Module: hyperbus_burst_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, DQ pins; internal word is 2*WIDTH bits.
REQ-002 SHALL have parameter ADDR_LENGTH, default 32, word address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, burst length field width.
REQ-004 SHALL have parameter TACC_COUNT, default 5, 1x initial latency in clk cycles.
REQ-005 SHALL have parameter FIXED_LATENCY, default 0; 1 forces 2x latency.
REQ-006 SHALL have parameters RESET_COUNT (default 2), RECOVER_COUNT (default 2, CS# high time), TIMEOUT_COUNT (default 16, read strobe timeout).
REQ-007 SHALL have ports: clk in 1, memory clock; rst in 1, reset. One clock; reset is synchronous and active-high.
REQ-008 SHALL have ports: cmd_valid_i in 1; cmd_ready_o out 1; cmd_we_i in 1 (1=write); cmd_reg_i in 1 (register space); cmd_adr_i in ADDR_LENGTH; cmd_len_i in LEN_WIDTH (words minus 1).
REQ-009 SHALL have ports: wdat_i in 2*WIDTH; wmask_i in 2 (1=byte not written); wvalid_i in 1; wready_o out 1.
REQ-010 SHALL have ports: rdat_o out 2*WIDTH; rvalid_o out 1; busy_o out 1; error_o out 1; err_clr_i in 1.
REQ-011 SHALL have PHY ports, SDR view of DDR pins, high half = rising edge: phy_dq_o out 2*WIDTH; phy_dq_oe out 1; phy_dq_i in 2*WIDTH; phy_rwds_o out 2; phy_rwds_oe out 1; phy_rwds_i in 2; phy_clk_en out 1; phy_csn out 1; phy_rstn out 1.

Function
REQ-012 SHALL implement states RESET, IDLE, COMMAND, LATENCY, WRITE, READ, RECOVER, ERROR; illegal encoding -> RESET.
REQ-013 RESET: phy_rstn=0, phy_csn=1, for RESET_COUNT+1 cycles, then IDLE.
REQ-014 IDLE: cmd_ready_o=1, busy_o=0, phy_csn=1; command accepted on cmd_valid_i&&cmd_ready_o; cmd_valid_i in any other state ignored.
REQ-015 On accept SHALL latch CA: [47]=~cmd_we_i, [46]=cmd_reg_i, [45]=1 (linear), [44:16]=cmd_adr_i[ADDR_LENGTH-1:3] zero-extended, [15:3]=0, [2:0]=cmd_adr_i[2:0]; latch len; register-space commands force len=0.
REQ-016 COMMAND: 3 cycles, phy_dq_o=CA[47:32],[31:16],[15:0] in order, phy_dq_oe=1, phy_csn=0, phy_clk_en=1.
REQ-017 Latency select SHALL sample phy_rwds_i in first COMMAND cycle: any bit high or FIXED_LATENCY=1 -> 2*TACC_COUNT cycles, else TACC_COUNT.
REQ-018 Register-space write SHALL skip LATENCY (zero latency), going COMMAND -> WRITE.
REQ-019 LATENCY: phy_dq_oe=0, phy_rwds_oe=0, phy_clk_en=1; on count expiry -> WRITE if write else READ.
REQ-020 WRITE: wready_o=1, phy_dq_oe=1, phy_rwds_oe=1 (register-space: phy_rwds_oe=0); phy_clk_en=wvalid_i; phy_dq_o=wdat_i, phy_rwds_o=wmask_i combinationally.
REQ-021 Word transfers on wvalid_i&&wready_o; wvalid_i low stalls (clock gated, CS# held low, no word counted).
REQ-022 After len+1 transferred words -> RECOVER.
REQ-023 READ: phy_clk_en=1, oe=0; when phy_rwds_i==2'b10, next cycle rvalid_o=1, rdat_o=phy_dq_i; rdat_o holds between strobes.
REQ-024 After len+1 read words -> RECOVER; phy_clk_en=0 from cycle after last strobe.
REQ-025 Read timeout counter SHALL reset on each strobe and on READ entry; TIMEOUT_COUNT cycles without strobe -> ERROR.
REQ-026 RECOVER: phy_csn=1, all oe=0, phy_clk_en=0, RECOVER_COUNT cycles, then IDLE.
REQ-027 ERROR: error_o=1, phy_csn=1, oe=0, clk_en=0, cmd_ready_o=0; err_clr_i -> RECOVER.
REQ-028 busy_o=1 in every state except IDLE; wready_o=0 outside WRITE; rvalid_o=0 outside READ (except final strobe's registered word).
REQ-029 Length counter SHALL be LEN_WIDTH bits; cmd_len_i=all-ones gives 2^LEN_WIDTH words without wrap-around error.

Reset
REQ-030 rst sampled high at any state, including mid-burst, SHALL on next edge give: state RESET, phy_rstn=0, phy_csn=1, phy_clk_en=0, phy_dq_oe=0, phy_rwds_oe=0, cmd_ready_o=0, wready_o=0, rvalid_o=0, error_o=0, busy_o=1, rdat_o=0, counters cleared, RESET_COUNT reloaded.

Verification
REQ-031 Reset release -> phy_rstn low 3 cycles (defaults), then cmd_ready_o=1, phy_csn=1.
REQ-032 Read adr=0x00000123, len=3, phy_rwds_i=00 during CA -> CA words A000,0024,0003; 5 latency cycles; four 2'b10 strobes -> four rvalid_o pulses, then RECOVER 2 cycles.
REQ-033 Write adr=0x10, len=1, phy_rwds_i=11 during CA -> 10 latency cycles; wvalid_i low 2 cycles mid-burst -> phy_clk_en=0 those cycles, exactly 2 words driven with wmask_i on phy_rwds_o.
REQ-034 Register write cmd_reg_i=1, len=5 -> CA[47:45]=011, WRITE immediately after COMMAND, one word only, phy_rwds_oe=0.
REQ-035 Read with no strobes -> ERROR after 16 cycles, error_o=1, phy_csn=1; err_clr_i=1 -> IDLE after RECOVER.
REQ-036 rst asserted during WRITE word 2 -> all REQ-030 values next cycle; no further word accepted.
